dll_active: RTL and testbench

- Active-state PCIe-style data link layer shim between the transaction layer and the physical/framing layer.
- TX: wraps outgoing TLPs with a 12-bit sequence number and a stub LCRC. It also builds UpdateFC DLLPs on request.
- RX: classifies incoming frames as DLLP or TLP, checks the stub CRC/LCRC and sequence number, and forwards accepted TLPs and decoded UpdateFC fields.

---
 rtl/dll_active.sv | 152 +++++++++++++++
 tb/tb_dll_active.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dll_active.sv
// Active-state data link layer shim: TX sequence/LCRC framing with UpdateFC DLLP arbitration,
// RX DLLP/TLP classification and checking. Define DLL_CRC_CHECK_EN to enforce RX CRC/LCRC.
module dll_active #(
    parameter logic [15:0] DLLP_CRC = 16'hBEEF,
    parameter logic [31:0] TLP_LCRC = 32'hDEADBEEF,
    parameter logic [11:0] SEQ_INIT = 12'd1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1195:0] rx_data_i,
    input  logic          rx_valid_i,
    output logic [1195:0] tx_data_o,
    output logic          tx_valid_o,
    input  logic [1151:0] tlp_i,
    input  logic          tlp_valid_i,
    input  logic [7:0]    hdr_credit_i,
    input  logic [11:0]   data_credit_i,
    input  logic [1:0]    update_type_i,
    input  logic          update_req_i,
    output logic          is_updatefc_o,
    output logic [1:0]    fc_type_o,
    output logic [5:0]    hdr_credit_o,
    output logic [11:0]   data_credit_o,
    output logic [1151:0] tlp_o,
    output logic          tlp_valid_o
);

    // RX state
    logic          is_updatefc_q, is_updatefc_d;
    logic [1:0]    fc_type_q, fc_type_d;
    logic [5:0]    hdr_q, hdr_d;
    logic [11:0]   data_q, data_d;
    logic [1151:0] tlp_q, tlp_d;
    logic          tlp_valid_q, tlp_valid_d;
    logic [11:0]   rcv_seq_q, rcv_seq_d;

    // TX state
    logic [1195:0] tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [11:0]   tx_seq_q, tx_seq_d;
    logic          fc_pend_q, fc_pend_d;
    logic [19:0]   fc_pend_data_q, fc_pend_data_d;

    logic       rx_is_dllp, dllp_crc_ok, tlp_crc_ok, dllp_ok, tlp_ok;
    logic [19:0] fc_req, fc_sel;
    logic        fc_avail;

    assign rx_is_dllp = (rx_data_i[1195:48] == '0);

`ifdef DLL_CRC_CHECK_EN
    assign dllp_crc_ok = (rx_data_i[47:32] == DLLP_CRC);
    assign tlp_crc_ok  = (rx_data_i[31:0] == TLP_LCRC);
`else
    assign dllp_crc_ok = 1'b1;
    assign tlp_crc_ok  = 1'b1;
`endif

    assign dllp_ok = rx_valid_i && rx_is_dllp && dllp_crc_ok && (rx_data_i[31:28] == 4'h8);
    assign tlp_ok  = rx_valid_i && !rx_is_dllp && tlp_crc_ok &&
                     (rx_data_i[1195:1184] == rcv_seq_q);

    // Reserved DLLP bits and, without CRC checking, the CRC fields are don't-care on RX.
    logic unused_rx;
    assign unused_rx = ^{hdr_credit_i[7:6], rx_data_i[47:32], rx_data_i[27:26],
                         rx_data_i[23:18]};

    always_comb begin
        is_updatefc_d = 1'b0;
        fc_type_d     = fc_type_q;
        hdr_d         = hdr_q;
        data_d        = data_q;
        tlp_valid_d   = 1'b0;
        tlp_d         = tlp_q;
        rcv_seq_d     = rcv_seq_q;
        if (dllp_ok) begin
            is_updatefc_d = 1'b1;
            fc_type_d     = rx_data_i[25:24];
            hdr_d         = rx_data_i[17:12];
            data_d        = rx_data_i[11:0];
        end
        if (tlp_ok) begin
            tlp_valid_d = 1'b1;
            tlp_d       = rx_data_i[1183:32];
            rcv_seq_d   = rcv_seq_q + 12'd1;
        end
    end

    assign fc_req = {update_type_i, hdr_credit_i[5:0], data_credit_i};

    always_comb begin
        tx_valid_d     = 1'b0;
        tx_data_d      = tx_data_q;
        tx_seq_d       = tx_seq_q;
        fc_pend_d      = fc_pend_q;
        fc_pend_data_d = fc_pend_data_q;
        // A fresh request bypasses (and supersedes) the pending register.
        fc_avail       = update_req_i | fc_pend_q;
        fc_sel         = update_req_i ? fc_req : fc_pend_data_q;
        if (tlp_valid_i) begin
            tx_valid_d     = 1'b1;
            tx_data_d      = {tx_seq_q, tlp_i, TLP_LCRC};
            tx_seq_d       = tx_seq_q + 12'd1;
            fc_pend_d      = fc_avail;
            fc_pend_data_d = fc_sel;
        end else if (fc_avail) begin
            tx_valid_d = 1'b1;
            tx_data_d  = {1148'b0, DLLP_CRC, 4'h8, 2'b00, fc_sel[19:18], 6'b0,
                          fc_sel[17:12], fc_sel[11:0]};
            fc_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_updatefc_q  <= 1'b0;
            fc_type_q      <= '0;
            hdr_q          <= '0;
            data_q         <= '0;
            tlp_q          <= '0;
            tlp_valid_q    <= 1'b0;
            rcv_seq_q      <= SEQ_INIT;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            tx_seq_q       <= SEQ_INIT;
            fc_pend_q      <= 1'b0;
            fc_pend_data_q <= '0;
        end else begin
            is_updatefc_q  <= is_updatefc_d;
            fc_type_q      <= fc_type_d;
            hdr_q          <= hdr_d;
            data_q         <= data_d;
            tlp_q          <= tlp_d;
            tlp_valid_q    <= tlp_valid_d;
            rcv_seq_q      <= rcv_seq_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            tx_seq_q       <= tx_seq_d;
            fc_pend_q      <= fc_pend_d;
            fc_pend_data_q <= fc_pend_data_d;
        end
    end

    assign is_updatefc_o = is_updatefc_q;
    assign fc_type_o     = fc_type_q;
    assign hdr_credit_o  = hdr_q;
    assign data_credit_o = data_q;
    assign tlp_o         = tlp_q;
    assign tlp_valid_o   = tlp_valid_q;
    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = tx_valid_q;

endmodule

// File: tb/tb_dll_active.sv
// Directed self-checking bench for dll_active: RX/TX framing, arbitration, reset and seq wrap.
module tb_dll_active;

    logic          clk = 1'b0;
    logic          rst;
    logic [1195:0] rx_data_i;
    logic          rx_valid_i;
    logic [1195:0] tx_data_o;
    logic          tx_valid_o;
    logic [1151:0] tlp_i;
    logic          tlp_valid_i;
    logic [7:0]    hdr_credit_i;
    logic [11:0]   data_credit_i;
    logic [1:0]    update_type_i;
    logic          update_req_i;
    logic          is_updatefc_o;
    logic [1:0]    fc_type_o;
    logic [5:0]    hdr_credit_o;
    logic [11:0]   data_credit_o;
    logic [1151:0] tlp_o;
    logic          tlp_valid_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dll_active dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tlp_i        (tlp_i),
        .tlp_valid_i  (tlp_valid_i),
        .hdr_credit_i (hdr_credit_i),
        .data_credit_i(data_credit_i),
        .update_type_i(update_type_i),
        .update_req_i (update_req_i),
        .is_updatefc_o(is_updatefc_o),
        .fc_type_o    (fc_type_o),
        .hdr_credit_o (hdr_credit_o),
        .data_credit_o(data_credit_o),
        .tlp_o        (tlp_o),
        .tlp_valid_o  (tlp_valid_o)
    );

    function automatic logic [1195:0] mk_tlp(input logic [11:0] seq, input logic [1151:0] pl,
                                             input logic [31:0] crc);
        return {seq, pl, crc};
    endfunction

    function automatic logic [1195:0] mk_dllp(input logic [47:0] low);
        return {1148'b0, low};
    endfunction

    task automatic idle_inputs();
        rx_data_i     = '0;
        rx_valid_i    = 1'b0;
        tlp_i         = '0;
        tlp_valid_i   = 1'b0;
        hdr_credit_i  = '0;
        data_credit_i = '0;
        update_type_i = '0;
        update_req_i  = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        vectors++;
        if (tx_valid_o !== 1'b0 || tlp_valid_o !== 1'b0 || is_updatefc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulses: got tx_valid=%b tlp_valid=%b updfc=%b want 0 0 0",
                     tx_valid_o, tlp_valid_o, is_updatefc_o);
        end
        vectors++;
        if (fc_type_o !== 2'b0 || hdr_credit_o !== 6'h0 || data_credit_o !== 12'h0) begin
            miscompares++;
            $display("FAIL reset_fc_fields: got %h %h %h want 0 0 0",
                     fc_type_o, hdr_credit_o, data_credit_o);
        end
        vectors++;
        if (tx_data_o !== '0) begin
            miscompares++;
            $display("FAIL reset_tx_data: got low %h want 0", tx_data_o[63:0]);
        end
        vectors++;
        if (tlp_o !== '0) begin
            miscompares++;
            $display("FAIL reset_tlp_o: got low %h want 0", tlp_o[63:0]);
        end
        rst = 1'b0;
    endtask

    task automatic test_rx_dllp();
        rx_data_i = mk_dllp(48'hBEEF_8A_00_55_11);
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        vectors++;
        if ({is_updatefc_o, fc_type_o, hdr_credit_o, data_credit_o} !==
            {1'b1, 2'b10, 6'h05, 12'h511}) begin
            miscompares++;
            $display("FAIL rx_dllp1: got %b %b %h %h want 1 10 05 511",
                     is_updatefc_o, fc_type_o, hdr_credit_o, data_credit_o);
        end
        rx_data_i = mk_dllp(48'hBEEF_8B_01_66_22);
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        vectors++;
        if ({is_updatefc_o, fc_type_o, hdr_credit_o, data_credit_o} !==
            {1'b1, 2'b11, 6'h16, 12'h622}) begin
            miscompares++;
            $display("FAIL rx_dllp2: got %b %b %h %h want 1 11 16 622",
                     is_updatefc_o, fc_type_o, hdr_credit_o, data_credit_o);
        end
        tick();
        vectors++;
        if ({is_updatefc_o, fc_type_o, hdr_credit_o, data_credit_o} !==
            {1'b0, 2'b11, 6'h16, 12'h622}) begin
            miscompares++;
            $display("FAIL rx_dllp_hold: got %b %b %h %h want 0 11 16 622",
                     is_updatefc_o, fc_type_o, hdr_credit_o, data_credit_o);
        end
    endtask

    task automatic test_rx_tlp();
        logic [1151:0] exp_pl;
        rx_data_i = mk_tlp(12'd1, '0, 32'hDEADBEEF);
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        vectors++;
        if (tlp_valid_o !== 1'b1 || tlp_o !== '0) begin
            miscompares++;
            $display("FAIL rx_tlp_seq1: got valid=%b low=%h want 1 0", tlp_valid_o, tlp_o[63:0]);
        end
        rx_data_i = mk_tlp(12'd1, '1, 32'hDEADBEEF);
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        vectors++;
        if (tlp_valid_o !== 1'b0 || tlp_o !== '0) begin
            miscompares++;
            $display("FAIL rx_tlp_dup: got valid=%b low=%h want 0 0", tlp_valid_o, tlp_o[63:0]);
        end
        exp_pl = {{576{1'b0}}, {576{1'b1}}};
        rx_data_i = mk_tlp(12'd2, exp_pl, 32'hDEADBEEF);
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        vectors++;
        if (tlp_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_tlp_seq2_valid: got %b want 1", tlp_valid_o);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (tlp_o[k*288 +: 288] !== exp_pl[k*288 +: 288]) begin
                miscompares++;
                $display("FAIL rx_tlp_seq2_pl[%0d]: got %h want %h", k, tlp_o[k*288 +: 288],
                         exp_pl[k*288 +: 288]);
            end
        end
        tick();
        vectors++;
        if (tlp_valid_o !== 1'b0 || tlp_o !== exp_pl) begin
            miscompares++;
            $display("FAIL rx_tlp_hold: got valid=%b low=%h want 0 %h", tlp_valid_o,
                     tlp_o[63:0], exp_pl[63:0]);
        end
    endtask

    task automatic test_rx_bad();
        logic [1151:0] pl3;
        logic          exp_first, exp_second, exp_dllp;
        pl3 = {{288{1'b1}}, {576{1'b0}}, {288{1'b1}}};
`ifdef DLL_CRC_CHECK_EN
        exp_first = 1'b0; exp_second = 1'b1; exp_dllp = 1'b0;
`else
        exp_first = 1'b1; exp_second = 1'b0; exp_dllp = 1'b1;
`endif
        rx_data_i = mk_tlp(12'd2, '1, 32'h0);
        rx_valid_i = 1'b1;
        tick();
        vectors++;
        if (tlp_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_seq2_badcrc: got valid=%b want 0", tlp_valid_o);
        end
        rx_data_i = mk_tlp(12'd3, pl3, 32'h0);
        tick();
        vectors++;
        if (tlp_valid_o !== exp_first) begin
            miscompares++;
            $display("FAIL rx_seq3_badcrc: got valid=%b want %b", tlp_valid_o, exp_first);
        end
        rx_data_i = mk_tlp(12'd3, pl3, 32'hDEADBEEF);
        tick();
        vectors++;
        if (tlp_valid_o !== exp_second) begin
            miscompares++;
            $display("FAIL rx_seq3_goodcrc: got valid=%b want %b", tlp_valid_o, exp_second);
        end
        vectors++;
        if (tlp_o !== pl3) begin
            miscompares++;
            $display("FAIL rx_seq3_pl: got low %h want %h", tlp_o[63:0], pl3[63:0]);
        end
        rx_data_i = mk_dllp(48'h1234_8A_00_55_11);
        tick();
        vectors++;
        if (is_updatefc_o !== exp_dllp) begin
            miscompares++;
            $display("FAIL rx_dllp_badcrc: got %b want %b", is_updatefc_o, exp_dllp);
        end
        rx_data_i = mk_dllp(48'hBEEF_4A_00_77_33);
        tick();
        rx_valid_i = 1'b0;
        vectors++;
        if (is_updatefc_o !== 1'b0 || data_credit_o === 12'h733) begin
            miscompares++;
            $display("FAIL rx_dllp_badtype: got updfc=%b data=%h want 0 not 733",
                     is_updatefc_o, data_credit_o);
        end
    endtask

    task automatic test_tx_dllp();
        update_type_i = 2'b01;
        hdr_credit_i  = 8'hA5;
        data_credit_i = 12'hBCD;
        update_req_i  = 1'b1;
        tick();
        update_req_i = 1'b0;
        vectors++;
        if (tx_valid_o !== 1'b1 || tx_data_o[47:0] !== 48'hBEEF_81_02_5B_CD) begin
            miscompares++;
            $display("FAIL tx_dllp: got valid=%b low=%h want 1 beef81025bcd", tx_valid_o,
                     tx_data_o[47:0]);
        end
        vectors++;
        if (tx_data_o[1195:48] !== '0) begin
            miscompares++;
            $display("FAIL tx_dllp_upper: got nonzero=%b want 0", |tx_data_o[1195:48]);
        end
        tick();
        vectors++;
        if (tx_valid_o !== 1'b0 || tx_data_o[47:0] !== 48'hBEEF_81_02_5B_CD) begin
            miscompares++;
            $display("FAIL tx_idle_hold: got valid=%b low=%h want 0 beef81025bcd", tx_valid_o,
                     tx_data_o[47:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1151:0] pl [3];
        pl[0] = '0;
        pl[1] = {{576{1'b1}}, {576{1'b0}}};
        pl[2] = {{288{1'b1}}, {576{1'b0}}, {288{1'b1}}};
        for (int i = 0; i < 3; i++) begin
            tlp_i = pl[i];
            tlp_valid_i = 1'b1;
            // First request is overwritten by the second before it can be sent.
            update_req_i = (i < 2);
            update_type_i = (i == 0) ? 2'b10 : 2'b00;
            hdr_credit_i  = (i == 0) ? 8'hC7 : 8'h3F;
            data_credit_i = (i == 0) ? 12'h123 : 12'h0AB;
            tick();
            vectors++;
            if (tx_valid_o !== 1'b1 || tx_data_o[1195:1184] !== 12'(i + 1) ||
                tx_data_o[31:0] !== 32'hDEADBEEF) begin
                miscompares++;
                $display("FAIL b2b_tlp%0d_hdr: got valid=%b seq=%0d lcrc=%h want 1 %0d deadbeef",
                         i, tx_valid_o, tx_data_o[1195:1184], tx_data_o[31:0], i + 1);
            end
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (tx_data_o[32 + k*288 +: 288] !== pl[i][k*288 +: 288]) begin
                    miscompares++;
                    $display("FAIL b2b_tlp%0d_pl[%0d]: got %h want %h", i, k,
                             tx_data_o[32 + k*288 +: 288], pl[i][k*288 +: 288]);
                end
            end
        end
        idle_inputs();
        tick();
        vectors++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== mk_dllp(48'hBEEF_80_03F0AB)) begin
            miscompares++;
            $display("FAIL b2b_dllp: got valid=%b low=%h want 1 beef8003f0ab", tx_valid_o,
                     tx_data_o[47:0]);
        end
        tick();
        vectors++;
        if (tx_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_stale_dllp: got valid=%b want 0", tx_valid_o);
        end
    endtask

    task automatic test_same_cycle();
        tlp_i = {1'b1, 1151'b0};
        tlp_valid_i = 1'b1;
        update_req_i = 1'b1;
        update_type_i = 2'b10;
        hdr_credit_i = 8'hC7;
        data_credit_i = 12'h123;
        tick();
        idle_inputs();
        vectors++;
        if (tx_valid_o !== 1'b1 || tx_data_o[1195:1184] !== 12'd4 ||
            tx_data_o[1183] !== 1'b1) begin
            miscompares++;
            $display("FAIL same_tlp: got valid=%b seq=%0d msb=%b want 1 4 1", tx_valid_o,
                     tx_data_o[1195:1184], tx_data_o[1183]);
        end
        tick();
        vectors++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== mk_dllp(48'hBEEF_82_007123)) begin
            miscompares++;
            $display("FAIL same_dllp: got valid=%b low=%h want 1 beef82007123", tx_valid_o,
                     tx_data_o[47:0]);
        end
    endtask

    task automatic test_reset_mid();
        tlp_valid_i = 1'b1;
        update_req_i = 1'b1;
        update_type_i = 2'b01;
        hdr_credit_i = 8'hA5;
        data_credit_i = 12'hBCD;
        tick();
        idle_inputs();
        vectors++;
        if (tx_valid_o !== 1'b1 || tx_data_o[1195:1184] !== 12'd5) begin
            miscompares++;
            $display("FAIL mid_tlp: got valid=%b seq=%0d want 1 5", tx_valid_o,
                     tx_data_o[1195:1184]);
        end
        rst = 1'b1;
        rx_data_i = mk_dllp(48'hBEEF_8A_00_55_11);
        rx_valid_i = 1'b1;
        tick();
        rst = 1'b0;
        rx_valid_i = 1'b0;
        vectors++;
        if (tx_valid_o !== 1'b0 || is_updatefc_o !== 1'b0 || tx_data_o !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got tx_valid=%b updfc=%b txlow=%h want 0 0 0",
                     tx_valid_o, is_updatefc_o, tx_data_o[47:0]);
        end
        tick();
        vectors++;
        if (tx_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_pending_discard: got valid=%b want 0", tx_valid_o);
        end
    endtask

    // Runs from reset: TX and RX both walk 4096 sequence numbers starting at 1, ending on 0.
    task automatic test_seq_wrap();
        logic [1151:0] pl;
        logic [11:0]   s;
        for (int i = 0; i < 4096; i++) begin
            s = 12'(i + 1);
            pl = {1'b1, 1139'b0, 12'(i)};
            tlp_i = pl;
            tlp_valid_i = 1'b1;
            rx_data_i = mk_tlp(s, pl, 32'hDEADBEEF);
            rx_valid_i = 1'b1;
            tick();
            vectors++;
            if (tx_valid_o !== 1'b1 || tx_data_o[1195:1184] !== s ||
                tx_data_o[43:32] !== 12'(i)) begin
                miscompares++;
                $display("FAIL wrap_tx[%0d]: got valid=%b seq=%0d pl=%h want 1 %0d %h", i,
                         tx_valid_o, tx_data_o[1195:1184], tx_data_o[43:32], s, 12'(i));
            end
            vectors++;
            if (tlp_valid_o !== 1'b1 || tlp_o[11:0] !== 12'(i) || tlp_o[1151] !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_rx[%0d]: got valid=%b pl=%h want 1 %h", i, tlp_valid_o,
                         tlp_o[11:0], 12'(i));
            end
        end
        idle_inputs();
        rx_data_i = mk_tlp(12'd0, {1'b1, 1151'b0}, 32'hDEADBEEF);
        rx_valid_i = 1'b1;
        tick();
        vectors++;
        if (tlp_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_rx_dup0: got valid=%b want 0", tlp_valid_o);
        end
        rx_data_i = mk_tlp(12'd1, {1'b1, 1151'b0}, 32'hDEADBEEF);
        tlp_valid_i = 1'b1;
        tick();
        idle_inputs();
        vectors++;
        if (tlp_valid_o !== 1'b1 || tx_data_o[1195:1184] !== 12'd1) begin
            miscompares++;
            $display("FAIL wrap_after0: got rx_valid=%b tx_seq=%0d want 1 1", tlp_valid_o,
                     tx_data_o[1195:1184]);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_rx_dllp();
        test_rx_tlp();
        test_rx_bad();
        test_tx_dllp();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid();
        test_seq_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
